// File: rtl/wb_load_align_stage.sv
// Registered MIPS writeback stage: load alignment/extension, LUI/ALU select, memory-wait with timeout.
// Optional misaligned-load detection is enabled by defining WB_ALIGN_CHK_EN.
module wb_load_align_stage #(
  parameter int BITS_SIZE      = 32,
  parameter int BYTE_BITS_SIZE = 8,
  parameter int HW_BITS        = 16,
  parameter int BITS_REGS      = 5,
  parameter int MEM_TIMEOUT    = 15,
  localparam int OFF_BITS      = $clog2(BITS_SIZE/8)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_reg_write,
  input  logic [BITS_REGS-1:0] i_rd,
  input  logic                 i_mem_to_reg,
  input  logic                 i_lui,
  input  logic [1:0]           i_size_filterL,
  input  logic                 i_zero_extend,
  input  logic [OFF_BITS-1:0]  i_addr_low,
  input  logic [BITS_SIZE-1:0] i_alu,
  input  logic [BITS_SIZE-1:0] i_extension,
  input  logic                 i_mem_rvalid,
  input  logic [BITS_SIZE-1:0] i_mem_rdata,
  output logic                 o_wb_valid,
  output logic                 o_wb_we,
  output logic [BITS_REGS-1:0] o_wb_rd,
  output logic [BITS_SIZE-1:0] o_wb_data,
  output logic                 o_stall,
  output logic                 o_timeout,
  output logic                 o_misalign
);

  localparam int CNT_BITS = $clog2(MEM_TIMEOUT + 1);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;

  logic [0:0]          state;
  logic [CNT_BITS-1:0] cnt;

  logic                 h_we;
  logic [BITS_REGS-1:0] h_rd;
  logic [1:0]           h_size;
  logic                 h_zext;
  logic [OFF_BITS-1:0]  h_off;

  logic is_load;
  logic we_req;
  logic misalign_in;

  function automatic logic [BITS_SIZE-1:0] filter(
    input logic [BITS_SIZE-1:0] rdata,
    input logic [1:0]           size,
    input logic                 zext,
    input logic [OFF_BITS-1:0]  off
  );
    logic [BITS_SIZE-1:0]      lane;
    logic [OFF_BITS-1:0]       hoff;
    logic [BYTE_BITS_SIZE-1:0] b;
    logic [HW_BITS-1:0]        h;
    logic [31:0]               w;
    lane = '0;
    hoff = {off[OFF_BITS-1:1], 1'b0};
    b    = '0;
    h    = '0;
    w    = '0;
    filter = '1;
    case (size)
      2'b01: begin
        lane   = rdata >> (BYTE_BITS_SIZE * off);
        b      = lane[BYTE_BITS_SIZE-1:0];
        filter = zext ? BITS_SIZE'(b) : BITS_SIZE'($signed(b));
      end
      2'b10: begin
        lane   = rdata >> (BYTE_BITS_SIZE * hoff);
        h      = lane[HW_BITS-1:0];
        filter = zext ? BITS_SIZE'(h) : BITS_SIZE'($signed(h));
      end
      2'b00: begin
        // On a 64-bit datapath the top offset bit picks the word; at 32 bits this is a pass-through.
        lane   = rdata >> (32 * ((BITS_SIZE == 64) ? int'(off[OFF_BITS-1]) : 0));
        w      = lane[31:0];
        filter = zext ? BITS_SIZE'(w) : BITS_SIZE'($signed(w));
      end
      default: filter = '1;
    endcase
  endfunction

  assign is_load = i_mem_to_reg & ~i_lui;
  assign we_req  = i_reg_write & (i_rd != '0);

`ifdef WB_ALIGN_CHK_EN
  assign misalign_in = is_load &&
                       ((i_size_filterL == 2'b10 && i_addr_low[0]) ||
                        (i_size_filterL == 2'b00 && i_addr_low[1:0] != 2'b00));
`else
  assign misalign_in = 1'b0;
`endif

  assign o_ready = (state == IDLE);
  assign o_stall = ~o_ready;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      h_we       <= 1'b0;
      h_rd       <= '0;
      h_size     <= '0;
      h_zext     <= 1'b0;
      h_off      <= '0;
      o_wb_valid <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_rd    <= '0;
      o_wb_data  <= '0;
      o_timeout  <= 1'b0;
      o_misalign <= 1'b0;
    end else begin
      o_wb_valid <= 1'b0;
      o_wb_we    <= 1'b0;
      o_timeout  <= 1'b0;
      o_misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (!is_load) begin
              o_wb_valid <= 1'b1;
              o_wb_we    <= we_req;
              o_wb_rd    <= i_rd;
              o_wb_data  <= i_lui ? i_extension : i_alu;
            end else if (misalign_in) begin
              o_wb_valid <= 1'b1;
              o_wb_rd    <= i_rd;
              o_misalign <= 1'b1;
            end else if (i_mem_rvalid) begin
              o_wb_valid <= 1'b1;
              o_wb_we    <= we_req;
              o_wb_rd    <= i_rd;
              o_wb_data  <= filter(i_mem_rdata, i_size_filterL, i_zero_extend, i_addr_low);
            end else begin
              h_we   <= we_req;
              h_rd   <= i_rd;
              h_size <= i_size_filterL;
              h_zext <= i_zero_extend;
              h_off  <= i_addr_low;
              cnt    <= '0;
              state  <= WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          // Data arriving on the final allowed cycle takes priority over the abort.
          if (i_mem_rvalid) begin
            o_wb_valid <= 1'b1;
            o_wb_we    <= h_we;
            o_wb_rd    <= h_rd;
            o_wb_data  <= filter(i_mem_rdata, h_size, h_zext, h_off);
            state      <= IDLE;
          end else if (cnt == CNT_BITS'(MEM_TIMEOUT - 1)) begin
            o_wb_valid <= 1'b1;
            o_wb_rd    <= h_rd;
            o_timeout  <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_load_align_stage.sv
// Scoreboard bench for wb_load_align_stage (32-bit datapath, MEM_TIMEOUT=15).
module tb_wb_load_align_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic        i_reg_write;
  logic [4:0]  i_rd;
  logic        i_mem_to_reg;
  logic        i_lui;
  logic [1:0]  i_size_filterL;
  logic        i_zero_extend;
  logic [1:0]  i_addr_low;
  logic [31:0] i_alu;
  logic [31:0] i_extension;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_wb_valid;
  logic        o_wb_we;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_stall;
  logic        o_timeout;
  logic        o_misalign;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk;
    logic        tmo;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 i_clk = ~i_clk;

  wb_load_align_stage #(
    .BITS_SIZE(32),
    .BYTE_BITS_SIZE(8),
    .HW_BITS(16),
    .BITS_REGS(5),
    .MEM_TIMEOUT(15)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_reg_write(i_reg_write), .i_rd(i_rd), .i_mem_to_reg(i_mem_to_reg), .i_lui(i_lui),
    .i_size_filterL(i_size_filterL), .i_zero_extend(i_zero_extend), .i_addr_low(i_addr_low),
    .i_alu(i_alu), .i_extension(i_extension), .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata(i_mem_rdata), .o_wb_valid(o_wb_valid), .o_wb_we(o_wb_we), .o_wb_rd(o_wb_rd),
    .o_wb_data(o_wb_data), .o_stall(o_stall), .o_timeout(o_timeout), .o_misalign(o_misalign)
  );

  function automatic exp_t mk(input logic we, input logic [4:0] rd, input logic [31:0] data,
                              input logic chk, input logic tmo, input logic mis);
    exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.chk = chk; e.tmo = tmo; e.mis = mis;
    return e;
  endfunction

  function automatic logic [31:0] model_filter(input logic [31:0] rdata, input logic [1:0] sz,
                                               input logic zx, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (sz)
      2'b01:   return zx ? {24'h0, b} : {{24{b[7]}}, b};
      2'b10:   return zx ? {16'h0, h} : {{16{h[15]}}, h};
      2'b00:   return rdata;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic exp_t load_exp(input logic rw, input logic [4:0] rd, input logic [1:0] sz,
                                    input logic zx, input logic [1:0] off, input logic [31:0] rdata);
    exp_t e;
    e = mk(rw && (rd != 5'd0), rd, model_filter(rdata, sz, zx, off), 1'b1, 1'b0, 1'b0);
`ifdef WB_ALIGN_CHK_EN
    if ((sz == 2'b10 && off[0]) || (sz == 2'b00 && off != 2'b00)) begin
      e.we = 1'b0; e.chk = 1'b0; e.mis = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic clear_inputs();
    i_valid = 0; i_reg_write = 0; i_rd = 0; i_mem_to_reg = 0; i_lui = 0;
    i_size_filterL = 0; i_zero_extend = 0; i_addr_low = 0; i_alu = 0; i_extension = 0;
    i_mem_rvalid = 0; i_mem_rdata = 0;
  endtask

  task automatic set_op(input logic rw, input logic [4:0] rd, input logic m2r, input logic lui,
                        input logic [1:0] sz, input logic zx, input logic [1:0] off,
                        input logic [31:0] alu, input logic [31:0] ext,
                        input logic rv, input logic [31:0] rdata);
    i_valid = 1; i_reg_write = rw; i_rd = rd; i_mem_to_reg = m2r; i_lui = lui;
    i_size_filterL = sz; i_zero_extend = zx; i_addr_low = off; i_alu = alu; i_extension = ext;
    i_mem_rvalid = rv; i_mem_rdata = rdata;
  endtask

  // Scoreboard: every writeback pulse must match the oldest pending expectation.
  always @(negedge i_clk) begin
    if (i_reset === 1'b1 && o_wb_valid === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", o_wb_rd, o_wb_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (o_wb_we !== e.we || o_wb_rd !== e.rd || o_timeout !== e.tmo ||
            o_misalign !== e.mis || (e.chk && o_wb_data !== e.data)) begin
          bad++;
          $display("FAIL wb_result: got we=%b rd=%0d data=%h tmo=%b mis=%b, required we=%b rd=%0d data=%h tmo=%b mis=%b",
                   o_wb_we, o_wb_rd, o_wb_data, o_timeout, o_misalign,
                   e.we, e.rd, e.data, e.tmo, e.mis);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic test_reset();
    i_reset = 0;
    clear_inputs();
    repeat (2) @(posedge i_clk);
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b required 1", o_ready); end
    total++; if (o_wb_valid !== 1'b0 || o_wb_we !== 1'b0 || o_timeout !== 1'b0 || o_misalign !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got valid=%b we=%b tmo=%b mis=%b required 0", o_wb_valid, o_wb_we, o_timeout, o_misalign);
    end
    total++; if (o_wb_data !== 32'h0 || o_wb_rd !== 5'd0) begin
      bad++; $display("FAIL reset_data: got rd=%0d data=%h required 0", o_wb_rd, o_wb_data);
    end
    i_reset = 1;
  endtask

  task automatic test_alu();
    @(posedge i_clk); #1;
    set_op(1, 5'd3, 0, 0, 2'b00, 0, 2'd0, 32'h0000_1234, 32'h0, 0, 32'h0);
    q.push_back(mk(1, 5'd3, 32'h0000_1234, 1, 0, 0));
    @(posedge i_clk); #1;
    total++; if (o_wb_valid !== 1'b1) begin bad++; $display("FAIL alu_latency: got valid=%b required 1", o_wb_valid); end
    set_op(1, 5'd0, 0, 0, 2'b00, 0, 2'd0, 32'h5555_AAAA, 32'h0, 0, 32'h0);
    q.push_back(mk(0, 5'd0, 32'h5555_AAAA, 1, 0, 0));
    @(posedge i_clk); #1;
    clear_inputs();
  endtask

  task automatic test_lb();
    @(posedge i_clk); #1;
    set_op(1, 5'd5, 1, 0, 2'b01, 0, 2'd2, 32'h0, 32'h0, 1, 32'h00A5_0000);
    q.push_back(mk(1, 5'd5, 32'hFFFF_FFA5, 1, 0, 0));
    @(posedge i_clk); #1;
    set_op(1, 5'd5, 1, 0, 2'b01, 1, 2'd2, 32'h0, 32'h0, 1, 32'h00A5_0000);
    q.push_back(mk(1, 5'd5, 32'h0000_00A5, 1, 0, 0));
    @(posedge i_clk); #1;
    clear_inputs();
  endtask

  task automatic test_lh_late();
    @(posedge i_clk); #1;
    set_op(1, 5'd4, 1, 0, 2'b10, 0, 2'd0, 32'h0, 32'h0, 0, 32'h0);
    q.push_back(mk(1, 5'd4, 32'hFFFF_8001, 1, 0, 0));
    @(posedge i_clk); #1;
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL lh_stall: cycle %0d got %b required 1", k, o_stall); end
      if (k == 2) begin i_mem_rvalid = 1; i_mem_rdata = 32'h0000_8001; end
      @(posedge i_clk); #1;
    end
    i_mem_rvalid = 0;
    total++; if (o_stall !== 1'b0 || o_wb_valid !== 1'b1) begin
      bad++; $display("FAIL lh_release: got stall=%b valid=%b required 0/1", o_stall, o_wb_valid);
    end
  endtask

  task automatic test_timeout();
    int n;
    @(posedge i_clk); #1;
    set_op(1, 5'd9, 1, 0, 2'b00, 0, 2'd0, 32'h0, 32'h0, 0, 32'h0);
    q.push_back(mk(0, 5'd9, 32'h0, 0, 1, 0));
    @(posedge i_clk); #1;
    clear_inputs();
    n = 0;
    while (o_stall === 1'b1 && n < 40) begin
      n++;
      @(posedge i_clk); #1;
    end
    total++; if (n != 15) begin bad++; $display("FAIL timeout_cycles: got %0d stall cycles required 15", n); end
    total++; if (o_timeout !== 1'b1 || o_wb_we !== 1'b0 || o_ready !== 1'b1) begin
      bad++; $display("FAIL timeout_flags: got tmo=%b we=%b ready=%b required 1/0/1", o_timeout, o_wb_we, o_ready);
    end
  endtask

  task automatic test_timeout_race();
    @(posedge i_clk); #1;
    set_op(1, 5'd10, 1, 0, 2'b00, 0, 2'd0, 32'h0, 32'h0, 0, 32'h0);
    q.push_back(mk(1, 5'd10, 32'hCAFE_F00D, 1, 0, 0));
    @(posedge i_clk); #1;
    clear_inputs();
    repeat (14) @(posedge i_clk);
    #1;
    i_mem_rvalid = 1; i_mem_rdata = 32'hCAFE_F00D;
    @(posedge i_clk); #1;
    i_mem_rvalid = 0;
    total++; if (o_wb_valid !== 1'b1 || o_timeout !== 1'b0) begin
      bad++; $display("FAIL race_data_wins: got valid=%b tmo=%b required 1/0", o_wb_valid, o_timeout);
    end
  endtask

  task automatic test_misalign_lui();
    @(posedge i_clk); #1;
    set_op(1, 5'd7, 1, 0, 2'b00, 0, 2'd1, 32'h0, 32'h0, 1, 32'hDEAD_BEEF);
    q.push_back(load_exp(1, 5'd7, 2'b00, 0, 2'd1, 32'hDEAD_BEEF));
    @(posedge i_clk); #1;
    set_op(1, 5'd0, 1, 1, 2'b00, 0, 2'd0, 32'h1111_1111, 32'h1234_0000, 0, 32'h0);
    q.push_back(mk(0, 5'd0, 32'h1234_0000, 1, 0, 0));
    @(posedge i_clk); #1;
    set_op(1, 5'd12, 1, 0, 2'b11, 0, 2'd0, 32'h0, 32'h0, 1, 32'h0000_0042);
    q.push_back(mk(1, 5'd12, 32'hFFFF_FFFF, 1, 0, 0));
    @(posedge i_clk); #1;
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    @(posedge i_clk); #1;
    set_op(1, 5'd6, 1, 0, 2'b00, 0, 2'd0, 32'h0, 32'h0, 0, 32'h0);
    @(posedge i_clk); #1;
    clear_inputs();
    @(posedge i_clk); #1;
    total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL midreset_waiting: got stall=%b required 1", o_stall); end
    i_reset = 0;
    #1;
    total++; if (o_ready !== 1'b1 || o_wb_valid !== 1'b0 || o_wb_we !== 1'b0 || o_wb_data !== 32'h0) begin
      bad++; $display("FAIL midreset_outputs: got ready=%b valid=%b we=%b data=%h required 1/0/0/0",
                      o_ready, o_wb_valid, o_wb_we, o_wb_data);
    end
    @(posedge i_clk); #1;
    i_reset = 1;
    i_mem_rvalid = 1; i_mem_rdata = 32'h7777_7777;
    @(posedge i_clk); #1;
    i_mem_rvalid = 0;
    total++; if (o_wb_valid !== 1'b0 || o_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_late_rvalid: got valid=%b ready=%b required 0/1", o_wb_valid, o_ready);
    end
  endtask

  task automatic test_random_loads();
    logic        rw, zx;
    logic [4:0]  rd;
    logic [1:0]  sz, off;
    logic [31:0] rdata;
    @(posedge i_clk); #1;
    for (int i = 0; i < 24; i++) begin
      rw = 1'($urandom_range(1)); zx = 1'($urandom_range(1));
      rd = 5'($urandom_range(31)); sz = 2'($urandom_range(3)); off = 2'($urandom_range(3));
      rdata = $urandom;
      set_op(rw, rd, 1, 0, sz, zx, off, 32'h0, 32'h0, 1, rdata);
      q.push_back(load_exp(rw, rd, sz, zx, off, rdata));
      @(posedge i_clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    @(posedge i_clk); #1;
    for (int i = 0; i < 6; i++) begin
      set_op(1, 5'(i + 20), 0, 0, 2'b00, 0, 2'd0, 32'h1000_0000 + 32'(i), 32'h0, 0, 32'h0);
      q.push_back(mk(1, 5'(i + 20), 32'h1000_0000 + 32'(i), 1, 0, 0));
      @(posedge i_clk); #1;
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: op %0d got %b required 1", i, o_ready); end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_lh_late();
    test_timeout();
    test_timeout_race();
    test_misalign_lui();
    test_mid_reset();
    test_random_loads();
    test_back_to_back();
    repeat (3) @(posedge i_clk);
    #1;
    total++; if (q.size() != 0) begin bad++; $display("FAIL drain: got %0d pending results required 0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
